uart_receiver: RTL and testbench

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_sync.sv | 23 ++
 rtl/uart_receiver.sv | 212 +++++++++++++++++++++
 tb/tb_uart_receiver.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default frame geometry,
// used by both the receiver and the transmitter.
package uart_pkg;

    localparam int UART_OVERSAMPLE_DEFAULT = 16;
    localparam int UART_DATA_BITS_DEFAULT  = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial input.
// Both flops reset to 1 so an idle (high) line is seen immediately after reset.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic d_async,
    output logic d_sync
);

    logic meta;

    // Double-register the line into the clk domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta   <= 1'b1;
            d_sync <= 1'b1;
        end else begin
            meta   <= d_async;
            d_sync <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// Oversampling UART receiver: start-bit mid-point qualification, LSB-first
// data, optional even-parity check, stop-bit framing check.
// Optional feature macro: UART_RX_PARITY_EN (adds the PARITY state and Rx_PERROR).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a low line on a tick while enabled
// START    | counting to mid start bit; low there accepts the frame
// DATA     | sampling one data bit every OVERSAMPLE ticks
// PARITY   | sampling the parity bit and comparing to even parity
// STOP     | sampling the stop bit, publishing data and status
module uart_receiver
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE_DEFAULT,
    parameter int DATA_BITS  = UART_DATA_BITS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_ENABLE,
    input  logic                 Rx_EN,
    input  logic                 Rx_D,
    output logic [DATA_BITS-1:0] Rx_DATA,
    output logic                 Rx_VALID,
    output logic                 Rx_FERROR,
    output logic                 Rx_PERROR
);

    localparam int CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    uart_state_e          state;
    uart_state_e          state_next;
    logic                 rx;
    logic [CNT_W-1:0]     tick_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 perr_now;

    logic cnt_clr;
    logic cnt_inc;
    logic shift_en;
    logic accept_start;
    logic stop_done;
`ifdef UART_RX_PARITY_EN
    logic par_chk;
`endif

    uart_rx_sync u_sync (
        .clk     (clk),
        .reset   (reset),
        .d_async (Rx_D),
        .d_sync  (rx)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and datapath strobes; only ticks move the FSM,
    // but a dropped enable returns to IDLE on any clk.
    always_comb begin
        state_next   = state;
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;
        shift_en     = 1'b0;
        accept_start = 1'b0;
        stop_done    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_chk      = 1'b0;
`endif
        if (!Rx_EN) begin
            state_next = ST_IDLE;
            cnt_clr    = 1'b1;
        end else if (sample_ENABLE) begin
            case (state)
                ST_IDLE: begin
                    if (!rx) begin
                        state_next = ST_START;
                        cnt_clr    = 1'b1;
                    end
                end
                ST_START: begin
                    if (tick_cnt == CNT_MID) begin
                        cnt_clr = 1'b1;
                        if (!rx) begin
                            state_next   = ST_DATA;
                            accept_start = 1'b1;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tick_cnt == CNT_LAST) begin
                        cnt_clr  = 1'b1;
                        shift_en = 1'b1;
                        if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_next = ST_PARITY;
`else
                            state_next = ST_STOP;
`endif
                        end
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (tick_cnt == CNT_LAST) begin
                        cnt_clr    = 1'b1;
                        par_chk    = 1'b1;
                        state_next = ST_STOP;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (tick_cnt == CNT_LAST) begin
                        cnt_clr    = 1'b1;
                        stop_done  = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    cnt_clr    = 1'b1;
                end
            endcase
        end
    end

    // Tick counter, bit counter, shift register, published data and status.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            Rx_DATA   <= '0;
            Rx_VALID  <= 1'b0;
            Rx_FERROR <= 1'b0;
        end else begin
            Rx_VALID <= 1'b0;
            if (cnt_clr) begin
                tick_cnt <= '0;
            end else if (cnt_inc) begin
                tick_cnt <= tick_cnt + 1'b1;
            end
            if (accept_start) begin
                bit_cnt   <= '0;
                Rx_FERROR <= 1'b0;
            end
            if (shift_en) begin
                // LSB first: each new bit enters at the top and walks down.
                shift_reg <= (shift_reg >> 1) | (DATA_BITS'(rx) << (DATA_BITS - 1));
                bit_cnt   <= bit_cnt + 1'b1;
            end
            if (stop_done) begin
                Rx_DATA <= shift_reg;
                if (!rx) begin
                    Rx_FERROR <= 1'b1;
                end
                if (rx && !perr_now) begin
                    Rx_VALID <= 1'b1;
                end
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic perr_pending;

    // Even-parity check; the error is held pending until the stop bit publishes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perr_pending <= 1'b0;
            Rx_PERROR    <= 1'b0;
        end else begin
            if (accept_start) begin
                perr_pending <= 1'b0;
                Rx_PERROR    <= 1'b0;
            end
            if (par_chk && (rx != ^shift_reg)) begin
                perr_pending <= 1'b1;
            end
            if (stop_done && perr_pending) begin
                Rx_PERROR <= 1'b1;
            end
        end
    end

    assign perr_now = perr_pending;
`else
    assign perr_now  = 1'b0;
    assign Rx_PERROR = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver (default geometry: 16x oversample,
// 8 data bits). Honors UART_RX_PARITY_EN when defined for the build.
module tb_uart_receiver;

    localparam int OS       = 16;
    localparam int DB       = 8;
    localparam int TICK_DIV = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          sample_ENABLE;
    logic          Rx_EN;
    logic          Rx_D;
    logic [DB-1:0] Rx_DATA;
    logic          Rx_VALID;
    logic          Rx_FERROR;
    logic          Rx_PERROR;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    logic [DB-1:0] exp_q[$];

`ifdef UART_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    uart_receiver #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
        .clk           (clk),
        .reset         (reset),
        .sample_ENABLE (sample_ENABLE),
        .Rx_EN         (Rx_EN),
        .Rx_D          (Rx_D),
        .Rx_DATA       (Rx_DATA),
        .Rx_VALID      (Rx_VALID),
        .Rx_FERROR     (Rx_FERROR),
        .Rx_PERROR     (Rx_PERROR)
    );

    always #5 clk = ~clk;

    // Baud sampler stand-in: one-clk tick every TICK_DIV clocks.
    initial begin
        sample_ENABLE = 1'b0;
        forever begin
            repeat (TICK_DIV - 1) @(negedge clk);
            sample_ENABLE = 1'b1;
            @(negedge clk);
            sample_ENABLE = 1'b0;
        end
    end

    // Scoreboard consumer: every Rx_VALID cycle must match the next expected word.
    initial begin
        logic [DB-1:0] exp_d;
        forever begin
            @(posedge clk);
            #1;
            if (Rx_VALID === 1'b1) begin
                pulses++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid: Rx_VALID=1 Rx_DATA=%h, no frame expected", Rx_DATA);
                end else begin
                    exp_d = exp_q.pop_front();
                    if (Rx_DATA !== exp_d) begin
                        errors++;
                        $display("FAIL valid_data: got %h expected %h", Rx_DATA, exp_d);
                    end
                    checks++;
                    if (Rx_FERROR !== 1'b0 || Rx_PERROR !== 1'b0) begin
                        errors++;
                        $display("FAIL valid_flags: ferr=%b perr=%b expected 0 0", Rx_FERROR, Rx_PERROR);
                    end
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(posedge clk); while (sample_ENABLE !== 1'b1);
        end
        #1;
    endtask

    task automatic send_bit(input logic b);
        Rx_D = b;
        wait_ticks(OS);
    endtask

    task automatic send_frame(input logic [DB-1:0] data, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < DB; i++) send_bit(data[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^data) ^ par_flip);
`endif
        send_bit(stop);
        Rx_D = 1'b1;
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, want);
        end
    endtask

    task automatic check_byte(input string name, input logic [DB-1:0] got, input logic [DB-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_byte("reset_data", Rx_DATA, 8'h00);
        check_bit("reset_valid", Rx_VALID, 1'b0);
        check_bit("reset_ferr", Rx_FERROR, 1'b0);
        check_bit("reset_perr", Rx_PERROR, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        send_bit(1'b1);
    endtask

    task automatic test_good_frame();
        int p0 = pulses;
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        send_bit(1'b1);
        check_int("good_pulses", pulses, p0 + 1);
        check_byte("good_data", Rx_DATA, 8'h55);
        check_bit("good_ferr", Rx_FERROR, 1'b0);
        check_bit("good_perr", Rx_PERROR, 1'b0);
    endtask

    task automatic test_parity();
        int p0 = pulses;
`ifdef UART_RX_PARITY_EN
        par_flip = 1'b1;
        send_frame(8'hA5, 1'b1);
        par_flip = 1'b0;
        send_bit(1'b1);
        check_int("perr_pulses", pulses, p0);
        check_bit("perr_flag", Rx_PERROR, 1'b1);
        check_bit("perr_ferr", Rx_FERROR, 1'b0);
        check_byte("perr_data", Rx_DATA, 8'hA5);
`else
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        send_bit(1'b1);
        check_int("noparity_pulses", pulses, p0 + 1);
        check_bit("noparity_perr", Rx_PERROR, 1'b0);
        check_byte("noparity_data", Rx_DATA, 8'hA5);
`endif
    endtask

    task automatic test_framing_error();
        int p0 = pulses;
        send_frame(8'h3C, 1'b0);
        send_bit(1'b1);
        check_int("ferr_pulses", pulses, p0);
        check_bit("ferr_flag", Rx_FERROR, 1'b1);
        check_bit("ferr_perr", Rx_PERROR, 1'b0);
        check_byte("ferr_data", Rx_DATA, 8'h3C);
    endtask

    task automatic test_false_start();
        int p0 = pulses;
        logic f0 = Rx_FERROR;
        logic e0 = Rx_PERROR;
        logic [DB-1:0] d0 = Rx_DATA;
        Rx_D = 1'b0;
        wait_ticks(4);
        Rx_D = 1'b1;
        wait_ticks(2 * OS);
        check_int("false_pulses", pulses, p0);
        check_bit("false_ferr_held", Rx_FERROR, f0);
        check_bit("false_perr_held", Rx_PERROR, e0);
        check_byte("false_data_held", Rx_DATA, d0);
    endtask

    task automatic test_error_clear();
        int p0 = pulses;
        exp_q.push_back(8'h01);
        send_frame(8'h01, 1'b1);
        send_bit(1'b1);
        check_int("clear_pulses", pulses, p0 + 1);
        check_bit("clear_ferr", Rx_FERROR, 1'b0);
        check_byte("clear_data", Rx_DATA, 8'h01);
    endtask

    task automatic test_enable_drop();
        int p0 = pulses;
        logic [DB-1:0] d0 = Rx_DATA;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        @(negedge clk);
        Rx_EN = 1'b0;
        Rx_D  = 1'b1;
        @(negedge clk);
        Rx_EN = 1'b1;
        send_bit(1'b1);
        check_int("endrop_pulses", pulses, p0);
        check_byte("endrop_data_held", Rx_DATA, d0);
        exp_q.push_back(8'h96);
        send_frame(8'h96, 1'b1);
        send_bit(1'b1);
        check_int("endrop_resume_pulses", pulses, p0 + 1);
        check_byte("endrop_resume_data", Rx_DATA, 8'h96);
        Rx_EN = 1'b0;
        send_frame(8'h5A, 1'b1);
        send_bit(1'b1);
        Rx_EN = 1'b1;
        send_bit(1'b1);
        check_int("disabled_pulses", pulses, p0 + 1);
        check_byte("disabled_data_held", Rx_DATA, 8'h96);
    endtask

    task automatic test_reset_mid_frame();
        int p0 = pulses;
        send_bit(1'b0);
        repeat (4) send_bit(1'b1);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_byte("midrst_data", Rx_DATA, 8'h00);
        check_bit("midrst_valid", Rx_VALID, 1'b0);
        check_bit("midrst_ferr", Rx_FERROR, 1'b0);
        check_bit("midrst_perr", Rx_PERROR, 1'b0);
        Rx_D = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        send_bit(1'b1);
        check_int("midrst_no_pulse", pulses, p0);
        exp_q.push_back(8'hFF);
        send_frame(8'hFF, 1'b1);
        send_bit(1'b1);
        check_int("midrst_pulses", pulses, p0 + 1);
        check_byte("midrst_after_data", Rx_DATA, 8'hFF);
    endtask

    task automatic test_back_to_back();
        int p0 = pulses;
        logic [DB-1:0] d;
        for (int i = 0; i < 4; i++) begin
            d = DB'($urandom_range(0, 255));
            exp_q.push_back(d);
            send_frame(d, 1'b1);
        end
        send_bit(1'b1);
        check_int("b2b_pulses", pulses, p0 + 4);
        check_byte("b2b_last_data", Rx_DATA, d);
    endtask

    initial begin
        Rx_D  = 1'b1;
        Rx_EN = 1'b1;
        reset = 1'b1;
        test_reset();
        test_good_frame();
        test_parity();
        test_framing_error();
        test_false_start();
        test_error_clear();
        test_enable_drop();
        test_reset_mid_frame();
        test_back_to_back();
        check_int("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
